// File: rtl/prbs_burst_ctrl.sv
// Burst PRBS generator: one command loads seed/taps/length, then N-bit Fibonacci LFSR bits stream out under valid/ready.
// Optional bits_sent_o status counter is enabled by defining PRBS_BURST_CTRL_STATUS_EN.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for a command; cmd_ready_o high
// RUN    | emitting shift_reg[N-1] on each data handshake
// DONE   | one-cycle completion pulse on done_o, then back to IDLE
module prbs_burst_ctrl #(
  parameter int N     = 8,
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [N-1:0]     cmd_seed_i,
  input  logic [N-1:0]     cmd_taps_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             abort_i,
  output logic             data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
`ifdef PRBS_BURST_CTRL_STATUS_EN
  ,
  output logic [LEN_W-1:0] bits_sent_o
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     shift_reg;
  logic [N-1:0]     taps;
  logic [LEN_W-1:0] remaining;
  logic             err_q;
  logic             cmd_hs;
  logic             data_hs;
  logic             seed_ok;
  logic             len_ok;

  assign cmd_hs  = cmd_valid_i & cmd_ready_o;
  assign data_hs = data_valid_o & data_ready_i;
  assign seed_ok = (cmd_seed_i != '0);
  assign len_ok  = (cmd_len_i != '0);

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (cmd_hs && seed_ok) state_d = len_ok ? S_RUN : S_DONE;
      end
      S_RUN: begin
        // abort wins even over the final transfer: no done pulse after an abort
        if (abort_i)                                   state_d = S_IDLE;
        else if (data_hs && remaining == LEN_W'(1))    state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready_o  = (state_q == S_IDLE);
    busy_o       = (state_q != S_IDLE);
    data_valid_o = (state_q == S_RUN);
    data_o       = (state_q == S_RUN) ? shift_reg[N-1] : 1'b0;
    done_o       = (state_q == S_DONE);
    err_o        = err_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_reg <= '0;
      taps      <= '0;
      remaining <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= cmd_hs & ~seed_ok;
      if (cmd_hs && seed_ok && len_ok) begin
        shift_reg <= cmd_seed_i;
        taps      <= cmd_taps_i;
        remaining <= cmd_len_i;
      end else if (data_hs) begin
        shift_reg <= {shift_reg[N-2:0], ^(shift_reg & taps)};
        remaining <= remaining - LEN_W'(1);
      end
    end
  end

`ifdef PRBS_BURST_CTRL_STATUS_EN
  always_ff @(posedge clk_i) begin
    if (reset_i)      bits_sent_o <= '0;
    else if (cmd_hs)  bits_sent_o <= '0;
    else if (data_hs) bits_sent_o <= bits_sent_o + LEN_W'(1);
  end
`endif

endmodule

// File: tb/tb_prbs_burst_ctrl.sv
// Directed bench for prbs_burst_ctrl (N=8): basic burst, backpressure, zero seed/length, abort and mid-burst reset.
module tb_prbs_burst_ctrl;

  localparam int N     = 8;
  localparam int LEN_W = 16;

  logic             clk_i = 1'b0;
  logic             reset_i;
  logic             cmd_valid_i;
  logic             cmd_ready_o;
  logic [N-1:0]     cmd_seed_i;
  logic [N-1:0]     cmd_taps_i;
  logic [LEN_W-1:0] cmd_len_i;
  logic             abort_i;
  logic             data_o;
  logic             data_valid_o;
  logic             data_ready_i;
  logic             busy_o;
  logic             done_o;
  logic             err_o;
`ifdef PRBS_BURST_CTRL_STATUS_EN
  logic [LEN_W-1:0] bits_sent_o;
`endif

  int n_vec  = 0;
  int n_miss = 0;

  // seed 0x01, taps 0x03: bit i is the i-th emitted bit (0,0,0,0,0,0,0,1)
  logic [7:0] exp_bits = 8'b1000_0000;

  always #5 clk_i = ~clk_i;

  prbs_burst_ctrl #(.N(N), .LEN_W(LEN_W)) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .cmd_valid_i  (cmd_valid_i),
    .cmd_ready_o  (cmd_ready_o),
    .cmd_seed_i   (cmd_seed_i),
    .cmd_taps_i   (cmd_taps_i),
    .cmd_len_i    (cmd_len_i),
    .abort_i      (abort_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .data_ready_i (data_ready_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o)
`ifdef PRBS_BURST_CTRL_STATUS_EN
    ,
    .bits_sent_o  (bits_sent_o)
`endif
  );

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk_vec({tag, " ready"}, 32'(cmd_ready_o), 32'd1);
    chk_vec({tag, " busy"},  32'(busy_o),      32'd0);
    chk_vec({tag, " valid"}, 32'(data_valid_o), 32'd0);
    chk_vec({tag, " data"},  32'(data_o),      32'd0);
    chk_vec({tag, " done"},  32'(done_o),      32'd0);
  endtask

  // holds the command across one edge; outputs are then sampled 1ns after that edge
  task automatic send_cmd(input logic [N-1:0] seed, input logic [N-1:0] taps, input logic [LEN_W-1:0] len);
    cmd_valid_i = 1'b1;
    cmd_seed_i  = seed;
    cmd_taps_i  = taps;
    cmd_len_i   = len;
    step();
    cmd_valid_i = 1'b0;
  endtask

  initial begin
    int idx;
    int cyc;
    logic rdy;

    reset_i      = 1'b1;
    cmd_valid_i  = 1'b1;
    cmd_seed_i   = 8'h01;
    cmd_taps_i   = 8'h03;
    cmd_len_i    = 16'd4;
    abort_i      = 1'b0;
    data_ready_i = 1'b1;
    step();
    step();
    cmd_valid_i = 1'b0;
    chk_idle("reset");
    chk_vec("reset err", 32'(err_o), 32'd0);
    reset_i = 1'b0;
    step();
    chk_idle("post-reset");

    // basic burst
    data_ready_i = 1'b1;
    send_cmd(8'h01, 8'h03, 16'd8);
    for (int i = 0; i < 8; i++) begin
      chk_vec($sformatf("basic valid[%0d]", i), 32'(data_valid_o), 32'd1);
      chk_vec($sformatf("basic bit[%0d]", i),   32'(data_o),       32'(exp_bits[i]));
      chk_vec($sformatf("basic done[%0d]", i),  32'(done_o),       32'd0);
      step();
    end
    chk_vec("basic done", 32'(done_o), 32'd1);
    chk_vec("basic valid after", 32'(data_valid_o), 32'd0);
    chk_vec("basic final shift_reg", 32'(dut.shift_reg), 32'hB6);
`ifdef PRBS_BURST_CTRL_STATUS_EN
    chk_vec("basic bits_sent", 32'(bits_sent_o), 32'd8);
`endif
    step();
    chk_idle("basic back to idle");

    // backpressure, with a conflicting command held during the burst
    send_cmd(8'h01, 8'h03, 16'd8);
    cmd_valid_i = 1'b1;
    cmd_seed_i  = 8'h00;
    cmd_taps_i  = 8'hFF;
    cmd_len_i   = 16'd1;
    idx = 0;
    cyc = 0;
    while (idx < 8 && cyc < 60) begin
      rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
      data_ready_i = rdy;
      chk_vec($sformatf("bp valid c%0d", cyc), 32'(data_valid_o), 32'd1);
      chk_vec($sformatf("bp bit c%0d", cyc),   32'(data_o),       32'(exp_bits[idx]));
      chk_vec($sformatf("bp err c%0d", cyc),   32'(err_o),        32'd0);
      step();
      if (rdy) idx++;
      cyc++;
    end
    chk_vec("bp bits transferred", 32'(idx), 32'd8);
    cmd_valid_i = 1'b0;
    chk_vec("bp done", 32'(done_o), 32'd1);
    chk_vec("bp final shift_reg", 32'(dut.shift_reg), 32'hB6);
    data_ready_i = 1'b1;
    step();
    chk_idle("bp back to idle");

    // zero seed rejected
    send_cmd(8'h00, 8'h03, 16'd5);
    chk_vec("zseed err", 32'(err_o), 32'd1);
    chk_idle("zseed");
    step();
    chk_vec("zseed err cleared", 32'(err_o), 32'd0);
    chk_idle("zseed after");

    // zero length
    send_cmd(8'h01, 8'h03, 16'd0);
    chk_vec("zlen done", 32'(done_o), 32'd1);
    chk_vec("zlen valid", 32'(data_valid_o), 32'd0);
    chk_vec("zlen err", 32'(err_o), 32'd0);
    step();
    chk_idle("zlen after");

    // abort at bit 3; the bit-3 handshake in the abort cycle still counts
    send_cmd(8'h01, 8'h03, 16'd8);
    step();
    step();
    step();
    chk_vec("abort bit3 valid", 32'(data_valid_o), 32'd1);
    abort_i = 1'b1;
    step();
    chk_idle("abort");
    chk_vec("abort shift_reg", 32'(dut.shift_reg), 32'h1B);
    // abort held while idle must not block a new command
    send_cmd(8'h01, 8'h03, 16'd2);
    abort_i = 1'b0;
    chk_vec("post-abort accepted", 32'(data_valid_o), 32'd1);
    step();
    step();
    chk_vec("post-abort done", 32'(done_o), 32'd1);
    step();
    chk_idle("post-abort idle");

    // reset mid-burst
    send_cmd(8'h01, 8'h03, 16'd8);
    step();
    step();
    step();
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    chk_idle("midreset");
    chk_vec("midreset err", 32'(err_o), 32'd0);
    chk_vec("midreset shift_reg", 32'(dut.shift_reg), 32'h00);
    chk_vec("midreset remaining", 32'(dut.remaining), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/prbs_burst_ctrl.md
PRBS_BURST_CTRL -- requirements
Module: prbs_burst_ctrl

Interface
REQ-001 Parameter N, default 8, LFSR width in bits (N >= 2).
REQ-002 Parameter LEN_W, default 16, burst-length field width in bits.
REQ-003 clk_i  input  1  sole clock; all logic on the rising edge.
REQ-004 reset_i  input  1  synchronous, active-high reset.
REQ-005 cmd_valid_i  input  1  burst command valid.
REQ-006 cmd_ready_o  output  1  block accepts a command (IDLE only).
REQ-007 cmd_seed_i  input  N  LFSR start value.
REQ-008 cmd_taps_i  input  N  LFSR feedback tap mask, bit i selects register bit i.
REQ-009 cmd_len_i  input  LEN_W  number of PRBS bits to emit.
REQ-010 abort_i  input  1  terminate the running burst.
REQ-011 data_o  output  1  current PRBS bit.
REQ-012 data_valid_o  output  1  data_o valid.
REQ-013 data_ready_i  input  1  sink accepts data_o.
REQ-014 busy_o  output  1  high in any state other than IDLE.
REQ-015 done_o  output  1  one-cycle pulse on normal burst completion.
REQ-016 err_o  output  1  one-cycle pulse when a command is rejected.

Function
REQ-017 The FSM SHALL have exactly these states: IDLE, RUN and DONE.
REQ-018 A command handshake SHALL occur when cmd_valid_i and cmd_ready_o are both high; cmd_ready_o SHALL equal (state == IDLE).
REQ-019 On a handshake with cmd_seed_i == 0, the block SHALL stay in IDLE, pulse err_o in the next cycle and emit no data.
REQ-020 On a handshake with a non-zero seed and cmd_len_i == 0, the block SHALL go to DONE and emit no data.
REQ-021 On a handshake with a non-zero seed and a non-zero length, the block SHALL latch seed into shift_reg, taps and len into the remaining counter, then enter RUN on the next edge.
REQ-022 In RUN, data_valid_o SHALL be 1 and data_o SHALL equal shift_reg[N-1]; in other states both SHALL be 0.
REQ-023 A data handshake (data_valid_o and data_ready_i) SHALL shift: shift_reg <= {shift_reg[N-2:0], ^(shift_reg & taps)}, remaining <= remaining - 1.
REQ-024 Without a data handshake, shift_reg, remaining and data_o SHALL hold, regardless of how long the stall lasts.
REQ-025 The handshake that transfers the last bit (remaining == 1) SHALL move the FSM to DONE.
REQ-026 DONE SHALL last exactly one cycle with done_o = 1, then return to IDLE.
REQ-027 abort_i in RUN SHALL force IDLE on the next edge with no done_o pulse; a data handshake in the same cycle counts as transferred.
REQ-028 abort_i outside RUN SHALL be ignored.
REQ-029 Command inputs SHALL be ignored outside IDLE; the latched taps and length SHALL be stable for the whole burst.

Reset
REQ-030 reset_i SHALL, on the next edge and from any state including mid-burst, force IDLE, shift_reg = 0, remaining = 0, and all outputs to 0 except cmd_ready_o.
REQ-031 cmd_ready_o SHALL be 1 in the first cycle after reset is released, and reset SHALL take priority over all other inputs.

Configuration
REQ-032 With macro PRBS_BURST_CTRL_STATUS_EN defined, the block SHALL add output bits_sent_o [LEN_W-1:0].
- Cleared on a command handshake and on reset.
- Incremented on each data handshake.
- Held after DONE or abort until the next command.
REQ-033 Without PRBS_BURST_CTRL_STATUS_EN, the bits_sent_o port and its counter SHALL be absent, and all other behaviour SHALL be identical.

Verification (N=8)
REQ-034 Basic burst: seed 0x01, taps 0x03, len 8, data_ready_i held 1.
- data_o sequence 0,0,0,0,0,0,0,1.
- Final shift_reg 0xB6.
- done_o pulses once; bits_sent_o = 8 when enabled.
REQ-035 Backpressure: same command, data_ready_i toggled 1,0,0,1,...
- Identical bit sequence.
- data_o and data_valid_o stable during stalls; no bits lost or duplicated.
REQ-036 Zero-seed rejection: seed 0x00, len 5.
- err_o pulses one cycle.
- data_valid_o never rises; busy_o stays 0.
REQ-037 Zero-length burst: seed 0x01, len 0.
- No data_valid_o.
- done_o pulses in the cycle after the handshake; then IDLE.
REQ-038 Abort and reset mid-burst:
- abort_i at bit 3 of a len-8 burst: IDLE next cycle, no done_o, new command accepted.
- reset_i at bit 3: all outputs reset on the next edge.
